// File: rtl/noncoh_acc_if.sv
// Signal bundle between the non-coherent accumulator, its sequencer and its two RAMs.
// slave: the accumulator's side. master: the sequencer/RAM side.
interface noncoh_acc_if #(
   parameter int NC_WIDTH = 16
);
   logic                    start;
   logic                    abort;
   logic                    first_noncoh;
   logic                    last_noncoh;
   logic [3:0]              max_exp;
   logic                    busy;
   logic                    done;
   logic                    coh_rd;
   logic [9:0]              coh_addr;
   logic [191:0]            coh_d4rd;
   logic                    nc_rd;
   logic [9:0]              nc_raddr;
   logic [8*NC_WIDTH-1:0]   nc_d4rd;
   logic                    nc_we;
   logic [9:0]              nc_waddr;
   logic [8*NC_WIDTH-1:0]   nc_d4wt;
   logic                    peak_valid;
   logic [NC_WIDTH-1:0]     peak_amp;
   logic [9:0]              peak_cor;
   logic [2:0]              peak_freq;

   modport slave (
      input  start, abort, first_noncoh, last_noncoh, max_exp, coh_d4rd, nc_d4rd,
      output busy, done, coh_rd, coh_addr, nc_rd, nc_raddr, nc_we, nc_waddr, nc_d4wt,
             peak_valid, peak_amp, peak_cor, peak_freq
   );

   modport master (
      output start, abort, first_noncoh, last_noncoh, max_exp, coh_d4rd, nc_d4rd,
      input  busy, done, coh_rd, coh_addr, nc_rd, nc_raddr, nc_we, nc_waddr, nc_d4wt,
             peak_valid, peak_amp, peak_cor, peak_freq
   );
endinterface

// File: rtl/noncoh_acc.sv
// Non-coherent accumulation: sweeps the coherent RAM once per start, adds per-lane amplitude
// estimates into the non-coherent RAM and, on the last round, tracks the peak cell.
module noncoh_acc #(
   parameter int COH_DATA_NUMBER = 682,
   parameter int NC_WIDTH        = 16
) (
   input  logic         clk,
   input  logic         rst_b,
   noncoh_acc_if.slave  bus
);
   localparam int                  LANES     = 8;
   localparam logic [9:0]          LAST_ADDR = 10'(COH_DATA_NUMBER - 1);
   localparam logic [NC_WIDTH-1:0] NC_MAX    = '1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   // Lane layout {I[9:0], Q[9:0], exp[3:0]}; magnitudes are 10-bit unsigned so |-512| = 512.
   function automatic logic [10:0] lane_amp(input logic [23:0] lane, input logic [3:0] max_exp);
      logic [9:0] i_mag;
      logic [9:0] q_mag;
      logic [9:0] hi;
      logic [9:0] lo;
      logic [3:0] sh;
      i_mag = lane[23] ? (~lane[23:14] + 10'd1) : lane[23:14];
      q_mag = lane[13] ? (~lane[13:4] + 10'd1) : lane[13:4];
      sh    = (lane[3:0] >= max_exp) ? 4'd0 : max_exp - lane[3:0];
      if (sh >= 4'd10) begin
         i_mag = '0;
         q_mag = '0;
      end else begin
         i_mag = i_mag >> sh;
         q_mag = q_mag >> sh;
      end
      hi = (i_mag >= q_mag) ? i_mag : q_mag;
      lo = (i_mag >= q_mag) ? q_mag : i_mag;
      return {1'b0, hi} + {2'b00, lo[9:1]};
   endfunction

   state_t                           state_q, state_d;
   logic [9:0]                       addr_q;
   logic [3:0]                       max_exp_q;
   logic                             first_q;
   logic                             last_q;

   logic                             s0_valid_q, s0_last_q;
   logic [9:0]                       s0_addr_q;
   logic                             s1_valid_q, s1_last_q;
   logic [9:0]                       s1_addr_q;
   logic [LANES-1:0][23:0]           s1_coh_q;
   logic [LANES-1:0][NC_WIDTH-1:0]   s1_old_q;
   logic                             s2_valid_q, s2_last_q;
   logic [9:0]                       s2_addr_q;
   logic [LANES-1:0][10:0]           s2_amp_q;
   logic [LANES-1:0][NC_WIDTH-1:0]   s2_old_q;

   logic [LANES-1:0][NC_WIDTH-1:0]   sum;
   logic                             pk_hit;
   logic [NC_WIDTH-1:0]              pk_amp_d;
   logic [2:0]                       pk_lane_d;

   logic                             peak_valid_q;
   logic [NC_WIDTH-1:0]              peak_amp_q;
   logic [9:0]                       peak_cor_q;
   logic [2:0]                       peak_freq_q;

   logic accept;
   logic abort_hit;
   logic issue;

   assign accept    = (state_q == IDLE) && bus.start;
   assign abort_hit = (state_q != IDLE) && bus.abort;
   assign issue     = (state_q == RUN);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (addr_q == LAST_ADDR) state_d = FLUSH;
         FLUSH:   if (s2_valid_q && s2_last_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_hit) state_d = IDLE;
   end

   // Sweep parameters are frozen at start; the address holds at the last entry once reached.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         addr_q    <= '0;
         max_exp_q <= '0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
      end else if (accept) begin
         addr_q    <= '0;
         max_exp_q <= bus.max_exp;
         first_q   <= bus.first_noncoh;
         last_q    <= bus.last_noncoh;
      end else if (issue && (addr_q != LAST_ADDR)) begin
         addr_q    <= addr_q + 10'd1;
      end
   end

   // NOTE: datapath registers are reset as well so every derived output reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         s0_valid_q <= 1'b0;
         s0_last_q  <= 1'b0;
         s0_addr_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_addr_q  <= '0;
         s1_coh_q   <= '0;
         s1_old_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_addr_q  <= '0;
         s2_amp_q   <= '0;
         s2_old_q   <= '0;
      end else begin
         s0_valid_q <= issue && !abort_hit;
         s0_last_q  <= (addr_q == LAST_ADDR);
         s0_addr_q  <= addr_q;

         s1_valid_q <= s0_valid_q && !abort_hit;
         s1_last_q  <= s0_last_q;
         s1_addr_q  <= s0_addr_q;
         s1_coh_q   <= bus.coh_d4rd;
         s1_old_q   <= first_q ? '0 : bus.nc_d4rd;

         s2_valid_q <= s1_valid_q && !abort_hit;
         s2_last_q  <= s1_last_q;
         s2_addr_q  <= s1_addr_q;
         for (int k = 0; k < LANES; k++) begin
            s2_amp_q[k] <= lane_amp(s1_coh_q[k], max_exp_q);
         end
         s2_old_q   <= s1_old_q;
      end
   end

   always_comb begin : acc_sum
      logic [NC_WIDTH:0] wide;
      wide = '0;
      sum  = '0;
      for (int k = 0; k < LANES; k++) begin
         wide   = {1'b0, s2_old_q[k]} + (NC_WIDTH+1)'(s2_amp_q[k]);
         sum[k] = wide[NC_WIDTH] ? NC_MAX : wide[NC_WIDTH-1:0];
      end
   end

   // Strictly-greater scan from lane 0 up: lowest lane wins a tie, earlier addresses win overall.
   always_comb begin
      pk_hit    = 1'b0;
      pk_amp_d  = peak_amp_q;
      pk_lane_d = '0;
      for (int k = 0; k < LANES; k++) begin
         if (sum[k] > pk_amp_d) begin
            pk_hit    = 1'b1;
            pk_amp_d  = sum[k];
            pk_lane_d = 3'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         peak_valid_q <= 1'b0;
         peak_amp_q   <= '0;
         peak_cor_q   <= '0;
         peak_freq_q  <= '0;
      end else if (accept && bus.last_noncoh) begin
         peak_valid_q <= 1'b0;
         peak_amp_q   <= '0;
         peak_cor_q   <= '0;
         peak_freq_q  <= '0;
      end else begin
         if (s2_valid_q && last_q && pk_hit) begin
            peak_amp_q  <= pk_amp_d;
            peak_cor_q  <= s2_addr_q;
            peak_freq_q <= pk_lane_d;
         end
         if ((state_q == DONE) && last_q && !abort_hit) peak_valid_q <= 1'b1;
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.coh_rd     = issue;
   assign bus.coh_addr   = addr_q;
   assign bus.nc_rd      = issue && !first_q;
   assign bus.nc_raddr   = addr_q;
   assign bus.nc_we      = s2_valid_q;
   assign bus.nc_waddr   = s2_addr_q;
   assign bus.nc_d4wt    = sum;
   assign bus.peak_valid = peak_valid_q;
   assign bus.peak_amp   = peak_amp_q;
   assign bus.peak_cor   = peak_cor_q;
   assign bus.peak_freq  = peak_freq_q;
endmodule

// File: tb/tb_noncoh_acc.sv
// Scoreboard bench for noncoh_acc: an integer reference model queues expected RAM writes,
// a negedge monitor pops and compares them as the DUT issues nc_we.
module tb_noncoh_acc;
   localparam int N = 682;
   localparam int W = 16;

   typedef struct packed {
      logic [9:0]   addr;
      logic [127:0] data;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_b = 1'b1;

   noncoh_acc_if #(.NC_WIDTH(W)) bus();

   noncoh_acc #(.COH_DATA_NUMBER(N), .NC_WIDTH(W)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [191:0] coh_mem [1024];
   logic [127:0] nc_mem  [1024];
   int ci [N][8];
   int cq [N][8];
   int ce [N][8];
   int ref_nc [N][8];
   int pk_amp, pk_cor, pk_freq;

   wr_t exp_q[$];
   int  cyc = 0, we_cnt = 0, done_cnt = 0, nc_rd_bad = 0;
   int  last_rd_cyc = 0, last_we_cyc = 0, done_cyc = 0;
   bit  cur_first = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Reference amplitude from the plain arithmetic definition.
   function automatic int amp_ref(input int i, input int q, input int e, input int me);
      int ai;
      int aq;
      int sh;
      ai = (i < 0) ? -i : i;
      aq = (q < 0) ? -q : q;
      sh = me - e;
      if (sh >= 10) begin
         ai = 0;
         aq = 0;
      end else if (sh > 0) begin
         ai = ai / (1 << sh);
         aq = aq / (1 << sh);
      end
      return ((ai > aq) ? ai : aq) + ((ai > aq) ? aq : ai) / 2;
   endfunction

   // RAM models: 1-cycle read latency, write on nc_we.
   always @(posedge clk) begin
      if (bus.coh_rd) bus.coh_d4rd <= coh_mem[bus.coh_addr];
      if (bus.nc_rd)  bus.nc_d4rd  <= nc_mem[bus.nc_raddr];
      if (bus.nc_we)  nc_mem[bus.nc_waddr] = bus.nc_d4wt;
   end

   always @(negedge clk) begin
      if (rst_b) begin
         cyc++;
         if (bus.coh_rd) last_rd_cyc = cyc;
         if (bus.nc_rd && cur_first) nc_rd_bad++;
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.nc_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("nc_we with nothing expected", 128'(bus.nc_we), 128'(0));
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               check("nc_waddr", 128'(bus.nc_waddr), 128'(w.addr));
               check("nc_d4wt", bus.nc_d4wt, w.data);
            end
         end
      end
   end

   task automatic fill_rand(input int mag);
      for (int a = 0; a < N; a++)
         for (int k = 0; k < 8; k++) begin
            ci[a][k] = int'($urandom_range(0, 2 * mag)) - mag;
            cq[a][k] = int'($urandom_range(0, 2 * mag)) - mag;
            ce[a][k] = int'($urandom_range(0, 15));
         end
   endtask

   task automatic load_coh();
      for (int a = 0; a < N; a++)
         for (int k = 0; k < 8; k++)
            coh_mem[a][24*k +: 24] = {10'(ci[a][k]), 10'(cq[a][k]), 4'(ce[a][k])};
   endtask

   task automatic build_expect(input bit first, input bit last, input int mexp);
      exp_q.delete();
      if (last) begin
         pk_amp  = 0;
         pk_cor  = 0;
         pk_freq = 0;
      end
      for (int a = 0; a < N; a++) begin
         wr_t w;
         w.addr = 10'(a);
         w.data = '0;
         for (int k = 0; k < 8; k++) begin
            int s;
            s = (first ? 0 : ref_nc[a][k]) + amp_ref(ci[a][k], cq[a][k], ce[a][k], mexp);
            if (s > 65535) s = 65535;
            ref_nc[a][k] = s;
            w.data[16*k +: 16] = 16'(s);
            if (last && s > pk_amp) begin
               pk_amp  = s;
               pk_cor  = a;
               pk_freq = k;
            end
         end
         exp_q.push_back(w);
      end
   endtask

   task automatic pulse_start(input bit first, input bit last, input int mexp);
      load_coh();
      build_expect(first, last, mexp);
      cur_first = first;
      we_cnt    = 0;
      done_cnt  = 0;
      nc_rd_bad = 0;
      tick();
      bus.start        = 1'b1;
      bus.first_noncoh = first;
      bus.last_noncoh  = last;
      bus.max_exp      = 4'(mexp);
      tick();
      bus.start        = 1'b0;
      bus.first_noncoh = ~first;
      bus.last_noncoh  = ~last;
      bus.max_exp      = 4'(15 - mexp);
   endtask

   task automatic run_sweep(input bit first, input bit last, input int mexp,
                            input int abort_at, input bit poke_start);
      int n;
      int we0;
      int we1;
      pulse_start(first, last, mexp);
      check("busy after start", 128'(bus.busy), 128'(1));
      if (last) check("peak_valid cleared at start", 128'(bus.peak_valid), 128'(0));
      if (poke_start) begin
         repeat (40) tick();
         bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
      end
      if (abort_at >= 0) begin
         n = 0;
         while (!(bus.coh_rd && bus.coh_addr == 10'(abort_at)) && n < 2000) begin
            tick();
            n++;
         end
         check("abort address reached", 128'(n < 2000), 128'(1));
         bus.abort = 1'b1;
         we0 = we_cnt;
         tick();
         bus.abort = 1'b0;
         check("idle after abort", 128'(bus.busy), 128'(0));
         repeat (3) tick();
         check("at most 3 writes after abort", 128'((we_cnt - we0) <= 3), 128'(1));
         we1 = we_cnt;
         repeat (10) tick();
         check("no writes after drain", 128'(we_cnt), 128'(we1));
         check("no done after abort", 128'(done_cnt), 128'(0));
         exp_q.delete();
      end else begin
         n = 0;
         while (done_cnt == 0 && n < 3000) begin
            tick();
            n++;
         end
         check("done within bound", 128'(n < 3000), 128'(1));
         tick();
         check("single done pulse", 128'(done_cnt), 128'(1));
         check("busy low after done", 128'(bus.busy), 128'(0));
         check("write count", 128'(we_cnt), 128'(N));
         check("expected writes drained", 128'(exp_q.size()), 128'(0));
         check("read-to-write latency", 128'(last_we_cyc - last_rd_cyc), 128'(3));
         check("done after last write", 128'(done_cyc - last_we_cyc), 128'(1));
         if (first) check("nc_rd while first_noncoh", 128'(nc_rd_bad), 128'(0));
         if (last) begin
            check("peak_valid", 128'(bus.peak_valid), 128'(1));
            check("peak_amp", 128'(bus.peak_amp), 128'(pk_amp));
            check("peak_cor", 128'(bus.peak_cor), 128'(pk_cor));
            check("peak_freq", 128'(bus.peak_freq), 128'(pk_freq));
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " control outputs"},
            128'({bus.busy, bus.done, bus.coh_rd, bus.nc_rd, bus.nc_we, bus.peak_valid}), 128'(0));
      check({tag, " addresses"},
            128'({bus.coh_addr, bus.nc_raddr, bus.nc_waddr, bus.peak_cor, bus.peak_freq}), 128'(0));
      check({tag, " nc_d4wt"}, bus.nc_d4wt, 128'(0));
      check({tag, " peak_amp"}, 128'(bus.peak_amp), 128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.first_noncoh = 1'b0;
      bus.last_noncoh  = 1'b0;
      bus.max_exp      = 4'd0;
      for (int a = 0; a < 1024; a++) begin
         coh_mem[a] = '0;
         nc_mem[a]  = '0;
      end
      #2 rst_b = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (3) tick();
      rst_b = 1'b1;
      tick();

      // Uniform lanes I=3, Q=-4 at max_exp 0: every lane becomes 4 + 1.
      for (int a = 0; a < N; a++)
         for (int k = 0; k < 8; k++) begin
            ci[a][k] = 3;
            cq[a][k] = -4;
            ce[a][k] = 0;
         end
      run_sweep(1'b1, 1'b0, 0, -1, 1'b0);
      check("uniform lane addr0", 128'(nc_mem[0][15:0]), 128'(5));
      check("uniform lane addr681", 128'(nc_mem[681][127:112]), 128'(5));

      // Alignment with max_exp 5.
      fill_rand(512);
      for (int a = 0; a < N; a++) begin
         ci[a][0] = 100;  cq[a][0] = 0; ce[a][0] = 2;
         ci[a][1] = 100;  cq[a][1] = 0; ce[a][1] = 5;
         ci[a][2] = -512; cq[a][2] = 0; ce[a][2] = 0;
         ci[a][3] = 0;    cq[a][3] = 0; ce[a][3] = 0;
      end
      run_sweep(1'b1, 1'b0, 5, -1, 1'b0);
      check("align sh3", 128'(nc_mem[7][15:0]), 128'(12));
      check("align sh0", 128'(nc_mem[7][31:16]), 128'(100));
      check("align -512 sh5", 128'(nc_mem[7][47:32]), 128'(16));
      check("align zero lane", 128'(nc_mem[7][63:48]), 128'(0));

      // Large shifts with max_exp 12.
      fill_rand(512);
      for (int a = 0; a < N; a++) begin
         ci[a][0] = 511;  cq[a][0] = -3;  ce[a][0] = 0;
         ci[a][1] = -512; cq[a][1] = 0;   ce[a][1] = 2;
         ci[a][2] = -512; cq[a][2] = 300; ce[a][2] = 3;
         ci[a][3] = 10;   cq[a][3] = -20; ce[a][3] = 13;
      end
      run_sweep(1'b1, 1'b0, 12, -1, 1'b0);
      check("align sh12", 128'(nc_mem[9][15:0]), 128'(0));
      check("align sh10", 128'(nc_mem[9][31:16]), 128'(0));
      check("align sh9", 128'(nc_mem[9][47:32]), 128'(1));
      check("align exp above max", 128'(nc_mem[9][63:48]), 128'(25));

      // Accumulate onto preloaded values, with a start pulse while busy.
      fill_rand(512);
      for (int a = 0; a < N; a++)
         for (int k = 0; k < 8; k++) begin
            int v;
            v = (a == 0) ? 65530 : (a == 1) ? 1000 : int'($urandom_range(0, 65535));
            nc_mem[a][16*k +: 16] = 16'(v);
            ref_nc[a][k] = v;
            if (a < 2) begin
               ci[a][k] = 100;
               cq[a][k] = 0;
               ce[a][k] = 0;
            end
         end
      run_sweep(1'b0, 1'b0, 0, -1, 1'b1);
      check("saturating add", 128'(nc_mem[0][127:112]), 128'(65535));
      check("plain add", 128'(nc_mem[1][15:0]), 128'(1100));

      // Peak search with a tie at a later address.
      fill_rand(200);
      for (int a = 0; a < N; a++)
         for (int k = 0; k < 8; k++) ce[a][k] = 0;
      ci[300][6] = 500;  cq[300][6] = -500;
      ci[500][2] = -500; cq[500][2] = 500;
      run_sweep(1'b1, 1'b1, 0, -1, 1'b0);
      check("peak tie address", 128'(bus.peak_cor), 128'(300));
      check("peak tie lane", 128'(bus.peak_freq), 128'(6));
      check("peak tie value", 128'(bus.peak_amp), 128'(750));

      // Abort mid-sweep, then a normal sweep.
      fill_rand(512);
      run_sweep(1'b1, 1'b0, 7, 200, 1'b0);
      fill_rand(512);
      run_sweep(1'b1, 1'b1, int'($urandom_range(0, 15)), -1, 1'b0);

      // Randomized accumulation rounds.
      for (int r = 0; r < 3; r++) begin
         fill_rand(512);
         run_sweep(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), -1, 1'b0);
      end

      // Make sure the peak registers hold something, then reset mid-sweep.
      fill_rand(512);
      run_sweep(1'b1, 1'b1, 3, -1, 1'b0);
      fill_rand(512);
      pulse_start(1'b1, 1'b0, 4);
      repeat (100) tick();
      rst_b = 1'b0;
      #1 check_reset_outputs("mid-sweep reset");
      repeat (2) tick();
      exp_q.delete();
      rst_b = 1'b1;
      tick();

      fill_rand(512);
      run_sweep(1'b1, 1'b1, int'($urandom_range(0, 15)), -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
